uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, the clk frequency in Hz.
REQ-002 Parameter BAUD, default 115200, the serial bit rate.
REQ-003 Port clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port RxD, input, 1 bit: asynchronous serial line; idles high; 8N1 frames, LSB first; compatible with the UART_Tx TxD output.
REQ-006 Port RxD_data, output, 8 bits: last good received byte.
REQ-007 Port RxD_data_ready, output, 1 bit: one-clk pulse when RxD_data has just been updated.
REQ-008 Port RxD_frame_err, output, 1 bit: one-clk pulse when a stop bit is sampled low.
REQ-009 Port RxD_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-010 RxD shall pass through a 2-flop synchroniser before any use; both flops reset to 1.
- Input latency is 2 clk.
REQ-011 An oversample tick shall fire once every DIV = CLK_FREQ/(BAUD*16) clk, using integer division (54 at the defaults).
- The tick counter shall restart at 0 on every IDLE->START transition.
REQ-012 States: IDLE, START, DATA, STOP, WAIT_HIGH (plus PARITY, per REQ-024).
REQ-013 IDLE: when synchronised RxD is 0, go to START and clear the tick count.
REQ-014 START: on the 8th tick (mid start bit):
- RxD still 0 -> go to DATA, bit index 0.
- RxD is 1 -> false start; return to IDLE with no output pulse.
REQ-015 DATA: on every 16th tick after that, sample RxD into the shift register at the current bit index (LSB first).
- After index 7 is sampled, go to STOP.
REQ-016 STOP: on the 16th tick (mid stop bit):
- RxD = 1 -> RxD_data <= shift register, RxD_data_ready = 1 for exactly the next clk, go to IDLE.
- RxD = 0 -> RxD_frame_err = 1 for one clk, RxD_data unchanged, go to WAIT_HIGH.
REQ-017 WAIT_HIGH: remain there until synchronised RxD is 1, then go to IDLE.
- A held-low line (break) therefore yields exactly one RxD_frame_err.
REQ-018 A falling edge of RxD in any state other than IDLE shall be ignored.
- Back-to-back frames, with the next start bit arriving right after the stop bit, shall be received without loss, because STOP returns to IDLE at mid stop bit.
REQ-019 RxD_data_ready and RxD_frame_err shall never be high in the same cycle.
REQ-020 The block has no consumer handshake.
- A byte not taken during its ready pulse is held on RxD_data until the next good frame overwrites it.

Reset
REQ-021 While rst = 1, at the next clk edge:
- state = IDLE, counters = 0.
- RxD_data = 8'h00, RxD_data_ready = 0, RxD_frame_err = 0, RxD_busy = 0.
- Synchroniser flops = 1.
REQ-022 Reset asserted mid-frame shall abort the frame with no pulse.
- After reset releases, reception resumes at the next falling edge seen in IDLE; a frame already in progress may be misframed, and this is accepted.

Configuration
REQ-023 Macro UART_RX_PARITY_EN selects the parity feature.
REQ-024 With UART_RX_PARITY_EN defined:
- The frame is 8E1; a PARITY state sits between DATA and STOP and samples the parity bit mid-bit.
- Output RxD_parity_err (1 bit) pulses for one clk, in the same cycle as RxD_data_ready, when the XOR of the 8 data bits and the parity bit is 1.
- RxD_data is updated regardless of parity.
REQ-025 Without UART_RX_PARITY_EN:
- The frame is 8N1.
- There is no PARITY state and no RxD_parity_err port.

Verification
REQ-026 CLK_FREQ = 1600000 and BAUD = 100000 (DIV = 1, 16 clk per bit) shall be used for all directed scenarios below.
REQ-027 Frame 0x55, then frame 0xAA -> two ready pulses; RxD_data = 8'h55, then 8'hAA; RxD_frame_err stays 0.
REQ-028 Output of UART_Tx sending 8'b10101010 fed into RxD -> exactly one ready pulse, RxD_data = 8'hAA.
REQ-029 RxD low for 5 clk, then high -> no pulse; RxD_busy returns to 0 within 12 clk.
REQ-030 Frame 0x3C with stop bit low, followed by 40 clk of low -> one RxD_frame_err pulse; RxD_data keeps its previous value; IDLE after RxD returns high.
REQ-031 rst asserted during data bit 4 of frame 0xF0 -> no pulse; all outputs at reset values; the next frame 0x0F is received correctly as 8'h0F.
REQ-032 With UART_RX_PARITY_EN: frame 0x07 with parity bit 0 -> RxD_data = 8'h07, RxD_parity_err pulses; same frame with parity bit 1 -> no RxD_parity_err.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling (16x) UART receiver, 8N1 by default.
// Define UART_RX_PARITY_EN to receive 8E1 frames and expose RxD_parity_err.
// The serial input is double-flopped, a 16x baud tick is derived from clk,
// and every bit is sampled at its middle by a single FSM.
module uart_rx #(
   parameter int unsigned CLK_FREQ = 100000000,
   parameter int unsigned BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RxD,
   output logic [7:0] RxD_data,
   output logic       RxD_data_ready,
   output logic       RxD_frame_err,
`ifdef UART_RX_PARITY_EN
   output logic       RxD_parity_err,
`endif
   output logic       RxD_busy
);

   // Oversample divider: one tick every DIV clk (never less than 1).
   localparam int unsigned DIV     = CLK_FREQ / (BAUD * 16);
   localparam int unsigned DIV_EFF = (DIV == 0) ? 1 : DIV;
   localparam int unsigned DIV_W   = (DIV_EFF > 1) ? $clog2(DIV_EFF) : 1;

   // Tick counts inside one bit: 8th tick is mid start bit, 16th is next mid-bit.
   localparam logic [3:0] TICK_MID  = 4'd7;
   localparam logic [3:0] TICK_LAST = 4'd15;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_HIGH = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd4,
      ST_WAIT_HIGH = 3'd5
   } state_t;
`endif

   state_t             state_q;
   logic               rx_meta_q;
   logic               rx_sync_q;
   logic [DIV_W-1:0]   div_cnt_q;
   logic [DIV_W-1:0]   div_cnt_d;
   logic               tick_c;
   logic [3:0]         tick_cnt_q;
   logic [2:0]         bit_idx_q;
   logic [7:0]         shift_q;
   logic [7:0]         data_q;
   logic               ready_q;
   logic               ferr_q;
   logic               busy_q;
`ifdef UART_RX_PARITY_EN
   logic               par_bit_q;
   logic               perr_q;
`endif

   // Two-flop synchroniser for the asynchronous line; idles (and resets) high.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= RxD;
         rx_sync_q <= rx_meta_q;
      end
   end

   // Divider next value; held at zero in IDLE so each frame starts a fresh tick phase.
   always_comb begin
      div_cnt_d = div_cnt_q;
      tick_c    = 1'b0;
      if (state_q == ST_IDLE) begin
         div_cnt_d = '0;
      end else if (div_cnt_q == DIV_W'(DIV_EFF - 1)) begin
         div_cnt_d = '0;
         tick_c    = 1'b1;
      end else begin
         div_cnt_d = div_cnt_q + DIV_W'(1);
      end
   end

   // Divider register.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

   // Receive FSM with registered data, pulse and busy outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         tick_cnt_q <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         ready_q    <= 1'b0;
         ferr_q     <= 1'b0;
         busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit_q  <= 1'b0;
         perr_q     <= 1'b0;
`endif
      end else begin
         ready_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q  <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               tick_cnt_q <= '0;
               bit_idx_q  <= '0;
               if (!rx_sync_q) begin
                  state_q <= ST_START;
                  busy_q  <= 1'b1;
               end
            end

            // Confirm the start bit at its middle; a high line there is a glitch.
            ST_START: begin
               if (tick_c) begin
                  if (tick_cnt_q == TICK_MID) begin
                     tick_cnt_q <= '0;
                     bit_idx_q  <= '0;
                     if (rx_sync_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                     end else begin
                        state_q <= ST_DATA;
                     end
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 4'd1;
                  end
               end
            end

            // Sample each data bit at its middle, LSB first.
            ST_DATA: begin
               if (tick_c) begin
                  tick_cnt_q <= tick_cnt_q + 4'd1;
                  if (tick_cnt_q == TICK_LAST) begin
                     shift_q[bit_idx_q] <= rx_sync_q;
                     if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_q <= ST_PARITY;
`else
                        state_q <= ST_STOP;
`endif
                     end else begin
                        bit_idx_q <= bit_idx_q + 3'd1;
                     end
                  end
               end
            end

`ifdef UART_RX_PARITY_EN
            // Capture the parity bit at its middle.
            ST_PARITY: begin
               if (tick_c) begin
                  tick_cnt_q <= tick_cnt_q + 4'd1;
                  if (tick_cnt_q == TICK_LAST) begin
                     par_bit_q <= rx_sync_q;
                     state_q   <= ST_STOP;
                  end
               end
            end
`endif

            // Mid stop bit: deliver the byte or flag a framing error.
            // Leaving here at mid-bit leaves half a bit to catch a back-to-back start.
            ST_STOP: begin
               if (tick_c) begin
                  tick_cnt_q <= tick_cnt_q + 4'd1;
                  if (tick_cnt_q == TICK_LAST) begin
                     if (rx_sync_q) begin
                        data_q  <= shift_q;
                        ready_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_q  <= ^{shift_q, par_bit_q};
`endif
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                     end else begin
                        ferr_q  <= 1'b1;
                        state_q <= ST_WAIT_HIGH;
                     end
                  end
               end
            end

            // Hold off after a framing error until the line is released.
            ST_WAIT_HIGH: begin
               if (rx_sync_q) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end

            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign RxD_data       = data_q;
   assign RxD_data_ready = ready_q;
   assign RxD_frame_err  = ferr_q;
   assign RxD_busy       = busy_q;
`ifdef UART_RX_PARITY_EN
   assign RxD_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed checks of uart_rx against a frame-level model.
// Frames are driven bit by bit at 16 clk per bit; the model predicts which bytes,
// framing errors and parity errors must appear at the outputs.
module tb_uart_rx;

   localparam int unsigned CLK_FREQ = 1600000;
   localparam int unsigned BAUD     = 100000;
   localparam int unsigned BIT_CLK  = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       RxD = 1'b1;
   logic [7:0] RxD_data;
   logic       RxD_data_ready;
   logic       RxD_frame_err;
   logic       RxD_busy;
`ifdef UART_RX_PARITY_EN
   logic       RxD_parity_err;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   // Observed events collected by the monitor.
   logic [7:0] rx_q[$];
   int ferr_cnt    = 0;
   int overlap_cnt = 0;
   int perr_cnt    = 0;
   int perr_lonely = 0;

   // Model state.
   logic [7:0] exp_q[$];
   logic [7:0] last_good;

   uart_rx #(
      .CLK_FREQ(CLK_FREQ),
      .BAUD    (BAUD)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .RxD           (RxD),
      .RxD_data      (RxD_data),
      .RxD_data_ready(RxD_data_ready),
      .RxD_frame_err (RxD_frame_err),
`ifdef UART_RX_PARITY_EN
      .RxD_parity_err(RxD_parity_err),
`endif
      .RxD_busy      (RxD_busy)
   );

   always #5 clk = ~clk;

   // Monitor: sample outputs on the falling edge.
   always @(negedge clk) begin
      if (RxD_data_ready) rx_q.push_back(RxD_data);
      if (RxD_frame_err) ferr_cnt++;
      if (RxD_data_ready && RxD_frame_err) overlap_cnt++;
`ifdef UART_RX_PARITY_EN
      if (RxD_parity_err) perr_cnt++;
      if (RxD_parity_err && !RxD_data_ready) perr_lonely++;
`endif
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input logic b);
      RxD = b;
      idle(BIT_CLK);
   endtask

   // One UART_Tx-style frame; parity (when enabled) is even and correct.
   task automatic send_frame(input logic [7:0] d, input logic stop_b);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(^d);
`endif
      drive_bit(stop_b);
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic send_frame_par(input logic [7:0] d, input logic par_b);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(par_b);
      drive_bit(1'b1);
   endtask
`endif

   // Compare everything received so far against the expected byte queue.
   task automatic drain_compare(input string tag);
      check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
      while (rx_q.size() > 0 && exp_q.size() > 0) begin
         check({tag, "_byte"}, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
      end
      rx_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int ferr_base;
      int k;
      logic [7:0] d;

      last_good = 8'h00;
      @(negedge clk);
      idle(3);

      // Reset values.
      check("rst_data",  32'(RxD_data), 32'h00);
      check("rst_ready", 32'(RxD_data_ready), 32'h0);
      check("rst_ferr",  32'(RxD_frame_err), 32'h0);
      check("rst_busy",  32'(RxD_busy), 32'h0);
      rst = 1'b0;
      idle(5);

      // 0x55 then 0xAA back to back.
      ferr_base = ferr_cnt;
      send_frame(8'h55, 1'b1); exp_q.push_back(8'h55);
      send_frame(8'hAA, 1'b1); exp_q.push_back(8'hAA); last_good = 8'hAA;
      idle(20);
      drain_compare("b2b");
      check("b2b_no_ferr", 32'(ferr_cnt - ferr_base), 32'd0);
      check("b2b_data", 32'(RxD_data), 32'(last_good));

      // Transmitter-style frame with idle line around it.
      idle(30);
      send_frame(8'b10101010, 1'b1); exp_q.push_back(8'hAA); last_good = 8'hAA;
      idle(30);
      drain_compare("tx");

      // Short low glitch: false start, no output.
      RxD = 1'b0;
      idle(5);
      check("glitch_busy_high", 32'(RxD_busy), 32'h1);
      RxD = 1'b1;
      k = 0;
      while (RxD_busy && k < 12) begin
         idle(1);
         k++;
      end
      check("glitch_busy_clear", 32'(RxD_busy), 32'h0);
      idle(20);
      drain_compare("glitch");
      check("glitch_no_ferr", 32'(ferr_cnt - ferr_base), 32'd0);

      // 0x3C with low stop bit, then 40 clk of break.
      ferr_base = ferr_cnt;
      send_frame(8'h3C, 1'b0);
      RxD = 1'b0;
      idle(40);
      check("ferr_busy_held", 32'(RxD_busy), 32'h1);
      check("ferr_count", 32'(ferr_cnt - ferr_base), 32'd1);
      check("ferr_data_kept", 32'(RxD_data), 32'(last_good));
      RxD = 1'b1;
      idle(6);
      check("ferr_idle_after", 32'(RxD_busy), 32'h0);
      drain_compare("ferr");

      // Reset during data bit 4 of 0xF0.
      d = 8'hF0;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d[i]);
      RxD = d[4];
      idle(8);
      rst = 1'b1;
      idle(2);
      check("midrst_data",  32'(RxD_data), 32'h00);
      check("midrst_ready", 32'(RxD_data_ready), 32'h0);
      check("midrst_ferr",  32'(RxD_frame_err), 32'h0);
      check("midrst_busy",  32'(RxD_busy), 32'h0);
      rst = 1'b0;
      RxD = 1'b1;
      last_good = 8'h00;
      idle(40);
      drain_compare("midrst_none");
      send_frame(8'h0F, 1'b1); exp_q.push_back(8'h0F); last_good = 8'h0F;
      idle(20);
      drain_compare("after_rst");
      check("after_rst_data", 32'(RxD_data), 32'h0F);

      // Randomized traffic: good frames with random gaps, occasional framing errors.
      ferr_base = ferr_cnt;
      k = 0;
      for (int it = 0; it < 24; it++) begin
         d = 8'($urandom);
         if ($urandom_range(0, 4) == 0) begin
            send_frame(d, 1'b0);
            RxD = 1'b0;
            idle($urandom_range(0, 30));
            RxD = 1'b1;
            idle($urandom_range(4, 12));
            k++;
         end else begin
            send_frame(d, 1'b1);
            exp_q.push_back(d);
            last_good = d;
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 20));
         end
      end
      idle(30);
      check("rand_ferr", 32'(ferr_cnt - ferr_base), 32'(k));
      check("rand_last_data", 32'(RxD_data), 32'(last_good));
      check("rand_idle", 32'(RxD_busy), 32'h0);
      drain_compare("rand");

`ifdef UART_RX_PARITY_EN
      // 0x07 has odd weight: parity 0 is wrong, parity 1 is right.
      begin
         int perr_base;
         perr_base = perr_cnt;
         send_frame_par(8'h07, 1'b0); exp_q.push_back(8'h07);
         idle(20);
         check("par_bad_perr", 32'(perr_cnt - perr_base), 32'd1);
         check("par_bad_data", 32'(RxD_data), 32'h07);
         drain_compare("par_bad");
         perr_base = perr_cnt;
         send_frame_par(8'h07, 1'b1); exp_q.push_back(8'h07);
         idle(20);
         check("par_good_perr", 32'(perr_cnt - perr_base), 32'd0);
         drain_compare("par_good");
         check("par_with_ready", 32'(perr_lonely), 32'd0);
      end
`endif

      check("ready_ferr_overlap", 32'(overlap_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
